// File: rtl/barrel_seq_shift_register.sv
// Multi-position shift register that performs one single-bit shift per cycle.
// It supports four fill modes, a start/busy/done handshake and a serial output.
module barrel_seq_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   data_q, data_n;
  logic               serial_q, serial_n;
  logic               done_q, done_n;
  logic [CNT_W-1:0]   remaining, remaining_n;
  logic               dir_q, dir_n;
  logic [1:0]         mode_q, mode_n;

  logic               fill;
  logic [WIDTH-1:0]   shifted;
  logic               shifted_out;

  // A single-bit shift of the current contents, using the direction and mode latched at start.
  always_comb begin
    fill        = 1'b0;
    shifted     = data_q;
    shifted_out = 1'b0;
    if (!dir_q) begin
      case (mode_q)
        2'b00:   fill = 1'b0;
        2'b01:   fill = data_q[WIDTH-1];
        2'b10:   fill = data_q[0];
        default: fill = serial_in;
      endcase
      shifted     = {fill, data_q[WIDTH-1:1]};
      shifted_out = data_q[0];
    end else begin
      case (mode_q)
        2'b10:   fill = data_q[WIDTH-1];
        2'b11:   fill = serial_in;
        default: fill = 1'b0;
      endcase
      shifted     = {data_q[WIDTH-2:0], fill};
      shifted_out = data_q[WIDTH-1];
    end
  end

  always_comb begin
    state_n     = state;
    data_n      = data_q;
    serial_n    = serial_q;
    done_n      = 1'b0;
    remaining_n = remaining;
    dir_n       = dir_q;
    mode_n      = mode_q;

    if (clear) begin
      state_n     = IDLE;
      data_n      = '0;
      serial_n    = 1'b0;
      remaining_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) data_n = data_in;
          if (start) begin
            dir_n       = dir;
            mode_n      = mode;
            remaining_n = amount;
            // A zero-length request completes immediately and does not enter SHIFT.
            if (amount == '0) done_n = 1'b1;
            else              state_n = SHIFT;
          end
        end
        SHIFT: begin
          data_n      = shifted;
          serial_n    = shifted_out;
          remaining_n = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data_q    <= '0;
      serial_q  <= 1'b0;
      done_q    <= 1'b0;
      remaining <= '0;
      dir_q     <= 1'b0;
      mode_q    <= 2'b00;
    end else begin
      state     <= state_n;
      data_q    <= data_n;
      serial_q  <= serial_n;
      done_q    <= done_n;
      remaining <= remaining_n;
      dir_q     <= dir_n;
      mode_q    <= mode_n;
    end
  end

  assign data_out   = data_q;
  assign serial_out = serial_q;
  assign busy       = (state == SHIFT);
  assign done       = done_q;

endmodule

// File: tb/tb_barrel_seq_shift_register.sv
// Scoreboard bench for barrel_seq_shift_register using directed vectors.
// Expected completion values are queued at start and popped by a done monitor.
module tb_barrel_seq_shift_register;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       load;
  logic [7:0] data_in;
  logic       start;
  logic       dir;
  logic [1:0] mode;
  logic [3:0] amount;
  logic       serial_in;
  logic [7:0] data_out;
  logic       serial_out;
  logic       busy;
  logic       done;

  typedef struct {
    logic [7:0] data;
    logic       serial;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  barrel_seq_shift_register #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .data_in(data_in),
    .start(start), .dir(dir), .mode(mode), .amount(amount), .serial_in(serial_in),
    .data_out(data_out), .serial_out(serial_out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs are driven for exactly one rising edge, then load/start drop.
  task automatic applyStimulus(input logic ld, input logic [7:0] d, input logic st,
                               input logic dr, input logic [1:0] md, input logic [3:0] amt);
    load = ld; data_in = d; start = st; dir = dr; mode = md; amount = amt;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
  endtask

  task automatic waitDone(input string name, input int exp_busy);
    int  busy_cycles = 0;
    bit  seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busy_cycles++;
      @(posedge clk); #1;
    end
    checkOutput({name, "_done_seen"}, 32'(seen), 32'd1);
    checkOutput({name, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
    checkOutput({name, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic pushExp(input logic [7:0] d, input logic s);
    exp_t e;
    e.data = d;
    e.serial = s;
    exp_q.push_back(e);
  endtask

  // The monitor pairs every done pulse with the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("sb_data", 32'(data_out), 32'(e.data));
        checkOutput("sb_serial", 32'(serial_out), 32'(e.serial));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit saw_done;
    rst = 1'b0; clear = 1'b0; load = 1'b0; data_in = '0; start = 1'b0;
    dir = 1'b0; mode = 2'b00; amount = '0; serial_in = 1'b0;
    #1 rst = 1'b1;
    #3;
    checkOutput("reset_data", 32'(data_out), 32'h00);
    checkOutput("reset_busy_done_serial", {29'd0, busy, done, serial_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Arithmetic right by 3 on 0xB4.
    applyStimulus(1'b1, 8'hB4, 1'b0, 1'b0, 2'b00, 4'd0);
    checkOutput("load_b4", 32'(data_out), 32'hB4);
    pushExp(8'hF6, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 4'd3);
    waitDone("asr3", 3);
    @(posedge clk); #1;
    checkOutput("asr3_done_one_cycle", 32'(done), 32'd0);

    // Rotate left by 3 with load in the same cycle as start.
    pushExp(8'h0C, 1'b0);
    applyStimulus(1'b1, 8'h81, 1'b1, 1'b1, 2'b10, 4'd3);
    checkOutput("rol_loaded", 32'(data_out), 32'h81);
    @(posedge clk); #1;
    checkOutput("rol_mid1", 32'(data_out), 32'h03);
    @(posedge clk); #1;
    checkOutput("rol_mid2", 32'(data_out), 32'h06);
    waitDone("rol3", 1);

    // Zero amount finishes without ever asserting busy.
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0, 2'b00, 4'd0);
    pushExp(8'h5A, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 2'b10, 4'd0);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    checkOutput("zero_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    checkOutput("zero_done_clears", 32'(done), 32'd0);
    checkOutput("zero_data", 32'(data_out), 32'h5A);

    // Serial fill right by 4, with a stray start while busy.
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 2'b00, 4'd0);
    serial_in = 1'b1;
    pushExp(8'hF0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 2'b11, 4'd4);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b1, 2'b00, 4'd2);
    waitDone("serial4", 3);
    serial_in = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    checkOutput("serial4_no_extra_done", 32'(saw_done), 32'd0);
    checkOutput("serial4_hold", 32'(data_out), 32'hF0);

    // Clear aborts a logical left shift after two steps.
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0, 2'b00, 4'd0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 2'b00, 4'd6);
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("clear_mid", 32'(data_out), 32'hFC);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checkOutput("clear_state", {22'd0, data_out, busy, serial_out}, 32'd0);
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    checkOutput("clear_no_done", 32'(saw_done), 32'd0);

    // Asynchronous reset between edges during a rotate right.
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 2'b00, 4'd0);
    pushExp(8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 2'b10, 4'd5);
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("rst_mid_data", 32'(data_out), 32'hCC);
    checkOutput("rst_mid_serial", 32'(serial_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_data", 32'(data_out), 32'h00);
    checkOutput("async_rst_flags", {29'd0, busy, done, serial_out}, 32'd0);
    exp_q.delete();
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back: new start accepted in the done cycle.
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 2'b00, 4'd0);
    pushExp(8'h80, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 2'b10, 4'd1);
    waitDone("ror1", 1);
    pushExp(8'h20, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 2'b00, 4'd2);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    waitDone("b2b_lsr2", 2);

    // Shift counts beyond the register width.
    applyStimulus(1'b1, 8'h81, 1'b0, 1'b0, 2'b00, 4'd0);
    pushExp(8'h03, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 2'b10, 4'd9);
    waitDone("rol9", 9);
    applyStimulus(1'b1, 8'h80, 1'b0, 1'b0, 2'b00, 4'd0);
    pushExp(8'hFF, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 2'b01, 4'd12);
    waitDone("asr12", 12);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
